servant_pc_trace: RTL

- Downstream monitor for the servant SoC simulation wrapper.
- Consumes the fetch-address strobe (instruction address plus fetch-ack valid) and records every fetched PC into a trace FIFO.
- Counts retired fetches and detects the self-loop ("j .") the firmware uses to signal end of test.
- The testbench drains the trace through a first-word-fall-through (FWFT) read port and watches the halt flag to stop simulation.

---
 rtl/servant_trace_pkg.sv | 21 ++
 rtl/servant_trace_fifo.sv | 65 ++++++
 rtl/servant_pc_trace.sv | 134 +++++++++++++
 3 files changed

// File: rtl/servant_trace_pkg.sv
// Shared types and constants for the servant PC trace monitor.
// Optional PC range filter in the top is enabled by SERVANT_PC_TRACE_FILTER_EN.
package servant_trace_pkg;

    localparam int unsigned DEPTH_DEF = 64;
    localparam int unsigned PTR_W     = $clog2(DEPTH_DEF) + 1;

    localparam logic [15:0] DROP_MAX  = 16'hFFFF;
    localparam logic [31:0] FETCH_MAX = 32'hFFFF_FFFF;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } loop_state_e;

    // Pointer width for a given depth: one extra wrap bit to tell full from empty.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/servant_trace_fifo.sv
// Synchronous first-word-fall-through FIFO with wrap-bit pointers and occupancy.
// Head data reads as zero while empty.
module servant_trace_fifo
    import servant_trace_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned W     = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clr,
    input  logic                          push,
    input  logic                          pop,
    input  logic [W-1:0]                  din,
    output logic [W-1:0]                  dout,
    output logic                          full,
    output logic                          empty,
    output logic [ptr_width(DEPTH)-1:0]   level
);

    localparam int unsigned PW = ptr_width(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          do_push, do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                   (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr) mem_q[wr_ptr_q[PW-2:0]] <= din;
    end

    assign dout  = empty ? '0 : mem_q[rd_ptr_q[PW-2:0]];
    assign level = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/servant_pc_trace.sv
// Fetch-PC trace monitor: FIFO capture, fetch/drop counters, end-of-test loop detector.
// Define SERVANT_PC_TRACE_FILTER_EN to add the filt_lo/filt_hi PC range filter.
module servant_pc_trace
    import servant_trace_pkg::*;
#(
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned LOOP_COUNT = 4,
    parameter int unsigned AW         = 32
) (
    input  logic                         wb_clk,
    input  logic                         wb_rst_n,
    input  logic [AW-1:0]                pc_adr,
    input  logic                         pc_vld,
    input  logic                         clr,
    input  logic                         rd_en,
`ifdef SERVANT_PC_TRACE_FILTER_EN
    input  logic [AW-1:0]                filt_lo,
    input  logic [AW-1:0]                filt_hi,
`endif
    output logic [AW-1:0]                rd_data,
    output logic                         rd_valid,
    output logic [$clog2(DEPTH):0]       level,
    output logic                         overflow,
    output logic [15:0]                  drop_cnt,
    output logic [31:0]                  fetch_cnt,
    output logic                         halted,
    output logic [AW-1:0]                halt_pc
);

    localparam logic [7:0] LOOP_TGT = 8'(LOOP_COUNT);

    logic        in_range, push_cand, drop;
    logic        fifo_full, fifo_empty;

    logic        overflow_q, overflow_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    loop_state_e state_q, state_d;
    logic [AW-1:0] last_pc_q, last_pc_d;
    logic [AW-1:0] halt_pc_q, halt_pc_d;
    logic [7:0]  rep_cnt_q, rep_cnt_d;

`ifdef SERVANT_PC_TRACE_FILTER_EN
    assign in_range = (pc_adr >= filt_lo) && (pc_adr <= filt_hi);
`else
    assign in_range = 1'b1;
`endif

    assign push_cand = pc_vld && in_range;
    // Full implies non-empty, so any rd_en frees the slot this push needs.
    assign drop      = push_cand && fifo_full && !rd_en;

    servant_trace_fifo #(
        .DEPTH (DEPTH),
        .W     (AW)
    ) u_fifo (
        .clk   (wb_clk),
        .rst_n (wb_rst_n),
        .clr   (clr),
        .push  (push_cand),
        .pop   (rd_en),
        .din   (pc_adr),
        .dout  (rd_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    always_comb begin
        overflow_d  = overflow_q;
        drop_cnt_d  = drop_cnt_q;
        fetch_cnt_d = fetch_cnt_q;
        state_d     = state_q;
        last_pc_d   = last_pc_q;
        halt_pc_d   = halt_pc_q;
        rep_cnt_d   = rep_cnt_q;
        if (clr) begin
            overflow_d  = 1'b0;
            drop_cnt_d  = '0;
            fetch_cnt_d = '0;
            state_d     = RUN;
            last_pc_d   = '0;
            halt_pc_d   = '0;
            rep_cnt_d   = '0;
        end else begin
            if (drop) begin
                overflow_d = 1'b1;
                if (drop_cnt_q != DROP_MAX) drop_cnt_d = drop_cnt_q + 16'd1;
            end
            if (pc_vld && fetch_cnt_q != FETCH_MAX) fetch_cnt_d = fetch_cnt_q + 32'd1;
            // rep_cnt of zero marks "no PC seen yet" so a first PC equal to the reset last_pc is not a repeat.
            if (pc_vld && state_q == RUN) begin
                if (rep_cnt_q != 8'd0 && pc_adr == last_pc_q) begin
                    rep_cnt_d = rep_cnt_q + 8'd1;
                    if (rep_cnt_q + 8'd1 == LOOP_TGT) begin
                        state_d   = HALT;
                        halt_pc_d = pc_adr;
                    end
                end else begin
                    rep_cnt_d = 8'd1;
                    last_pc_d = pc_adr;
                end
            end
        end
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            overflow_q  <= 1'b0;
            drop_cnt_q  <= '0;
            fetch_cnt_q <= '0;
            state_q     <= RUN;
            last_pc_q   <= '0;
            halt_pc_q   <= '0;
            rep_cnt_q   <= '0;
        end else begin
            overflow_q  <= overflow_d;
            drop_cnt_q  <= drop_cnt_d;
            fetch_cnt_q <= fetch_cnt_d;
            state_q     <= state_d;
            last_pc_q   <= last_pc_d;
            halt_pc_q   <= halt_pc_d;
            rep_cnt_q   <= rep_cnt_d;
        end
    end

    assign rd_valid  = !fifo_empty;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;
    assign fetch_cnt = fetch_cnt_q;
    assign halted    = (state_q == HALT);
    assign halt_pc   = halt_pc_q;

endmodule
